// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared CRC-8 constants, types and reference function
package crc_pkg;

    localparam int CRC_W = 8;

    typedef logic [CRC_W-1:0] crc_t;

    localparam crc_t DEFAULT_POLY   = 8'h36;
    localparam crc_t DEFAULT_INIT   = 8'h00;
    localparam crc_t DEFAULT_XOROUT = 8'h00;

    // MSB-first, non-reflected CRC-8 of a single byte; implicit x^8 term
    function automatic crc_t crc8_byte(input crc_t data, input crc_t init,
                                       input crc_t poly, input crc_t xorout);
        crc_t r;
        r = init ^ data;
        for (int i = 0; i < CRC_W; i++) begin
            if (r[CRC_W-1]) begin
                r = (r << 1) ^ poly;
            end else begin
                r = r << 1;
            end
        end
        return r ^ xorout;
    endfunction

endpackage

// File: rtl/check_crc_if.sv
// rtl/check_crc_if.sv - data/checksum inputs and verdict outputs of the checker
interface check_crc_if;
    import crc_pkg::*;

    crc_t dado;
    crc_t crc;
    logic ck_crc;
    logic ck_alarme;
    crc_t newcrc;

    // Sensor side drives the byte and its checksum, observes the verdict
    modport master (
        output dado,
        output crc,
        input  ck_crc,
        input  ck_alarme,
        input  newcrc
    );

    // Checker side
    modport slave (
        input  dado,
        input  crc,
        output ck_crc,
        output ck_alarme,
        output newcrc
    );

endinterface

// File: rtl/crc8_calc.sv
// rtl/crc8_calc.sv - combinational CRC-8 of one byte, unrolled 8-step shift
module crc8_calc
    import crc_pkg::*;
#(
    parameter crc_t POLY   = DEFAULT_POLY,
    parameter crc_t INIT   = DEFAULT_INIT,
    parameter crc_t XOROUT = DEFAULT_XOROUT
) (
    input  crc_t dado,
    output crc_t crc_out
);

    crc_t r;

    // One shift step per data bit; the bit shifted out of r[7] selects the poly XOR
    always_comb begin
        r = INIT ^ dado;
        for (int i = 0; i < CRC_W; i++) begin
            if (r[CRC_W-1]) begin
                r = (r << 1) ^ POLY;
            end else begin
                r = r << 1;
            end
        end
        crc_out = r ^ XOROUT;
    end

endmodule

// File: rtl/check_crc.sv
// rtl/check_crc.sv - CRC-8 integrity checker with registered match/alarm verdict
module check_crc
    import crc_pkg::*;
#(
    parameter crc_t POLY   = DEFAULT_POLY,
    parameter crc_t INIT   = DEFAULT_INIT,
    parameter crc_t XOROUT = DEFAULT_XOROUT
) (
    input  logic         clk,
    input  logic         rst,
    check_crc_if.slave   bus
);

    crc_t calc_crc;
    logic match;

    crc_t newcrc_d;
    crc_t newcrc_q;
    logic ck_crc_d;
    logic ck_crc_q;
    logic ck_alarme_d;
    logic ck_alarme_q;

    crc8_calc #(
        .POLY   (POLY),
        .INIT   (INIT),
        .XOROUT (XOROUT)
    ) u_calc (
        .dado    (bus.dado),
        .crc_out (calc_crc)
    );

    // Compare the recomputed CRC against the received one; the verdict pair is
    // complementary whenever a real comparison is registered
    always_comb begin
        match       = (calc_crc == bus.crc);
        newcrc_d    = calc_crc;
        ck_crc_d    = match;
        ck_alarme_d = ~match;
    end

    // Output register stage; reset forces the "no verdict yet" state (both flags low)
    always_ff @(posedge clk) begin
        if (rst) begin
            newcrc_q    <= '0;
            ck_crc_q    <= 1'b0;
            ck_alarme_q <= 1'b0;
        end else begin
            newcrc_q    <= newcrc_d;
            ck_crc_q    <= ck_crc_d;
            ck_alarme_q <= ck_alarme_d;
        end
    end

    assign bus.newcrc    = newcrc_q;
    assign bus.ck_crc    = ck_crc_q;
    assign bus.ck_alarme = ck_alarme_q;

endmodule

// File: tb/tb_check_crc.sv
// tb/tb_check_crc.sv - randomized self-checking bench for check_crc
module tb_check_crc;

    logic clk;
    logic rst;

    int n_tests;
    int n_failed;

    check_crc_if bus ();

    check_crc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remainder of (byte * x^8) divided by the generator x^8 + 0x36
    function automatic logic [7:0] model_crc(input logic [7:0] data);
        logic [15:0] dividend;
        logic [15:0] gen;
        dividend = {8'h00 ^ data, 8'h00};
        gen      = 16'h0136;
        for (int b = 15; b >= 8; b--) begin
            if (dividend[b]) begin
                dividend = dividend ^ (gen << (b - 8));
            end
        end
        return dividend[7:0] ^ 8'h00;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a pair before an edge, then check the registered verdict just after it
    task automatic step(input string tag, input logic [7:0] d, input logic [7:0] c);
        logic [7:0] exp_crc;
        logic       exp_match;
        @(negedge clk);
        bus.dado = d;
        bus.crc  = c;
        exp_crc   = model_crc(d);
        exp_match = (exp_crc == c);
        @(posedge clk);
        #1;
        check_eq({tag, ".newcrc"}, 32'(bus.newcrc), 32'(exp_crc));
        check_eq({tag, ".ck_crc"}, 32'(bus.ck_crc), 32'(exp_match));
        check_eq({tag, ".ck_alarme"}, 32'(bus.ck_alarme), 32'(!exp_match));
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, ".newcrc"}, 32'(bus.newcrc), 32'h00);
        check_eq({tag, ".ck_crc"}, 32'(bus.ck_crc), 32'h0);
        check_eq({tag, ".ck_alarme"}, 32'(bus.ck_alarme), 32'h0);
    endtask

    initial begin
        logic [7:0] g;
        logic [7:0] d;
        logic [7:0] c;
        logic [7:0] held_crc;
        logic       held_ck;
        n_tests  = 0;
        n_failed = 0;

        // Reset for two cycles with arbitrary inputs
        rst      = 1'b1;
        bus.dado = 8'($urandom);
        bus.crc  = 8'($urandom);
        repeat (2) begin
            @(posedge clk);
            #1;
            check_reset_state("reset");
            bus.dado = 8'($urandom);
            bus.crc  = 8'($urandom);
        end

        // Release: first verdict one edge later
        @(negedge clk);
        rst = 1'b0;
        step("first", 8'h01, 8'h36);

        // Directed cases
        step("d00_c37", 8'h00, 8'h37);
        step("d00_c38", 8'h00, 8'h38);
        step("d00_c00", 8'h00, 8'h00);
        step("d01_c36", 8'h01, 8'h36);
        step("d01_c37", 8'h01, 8'h37);
        check_eq("known_crc01", 32'(model_crc(8'h01)), 32'h36);

        // Full sweep: golden checksum then a one-bit corrupted one
        for (int i = 0; i < 256; i++) begin
            g = model_crc(8'(i));
            step("sweep_match", 8'(i), g);
            step("sweep_mismatch", 8'(i), g ^ 8'h01);
        end

        // Random pairs, about half carrying the correct checksum; inputs
        // wiggled between edges must not disturb the registered outputs
        for (int i = 0; i < 300; i++) begin
            d = 8'($urandom);
            c = ($urandom_range(0, 1) == 1) ? model_crc(d) : 8'($urandom);
            step("rand", d, c);
            held_crc = bus.newcrc;
            held_ck  = bus.ck_crc;
            bus.dado = 8'($urandom);
            bus.crc  = 8'($urandom);
            #2;
            check_eq("hold.newcrc", 32'(bus.newcrc), 32'(held_crc));
            check_eq("hold.ck_crc", 32'(bus.ck_crc), 32'(held_ck));
        end

        // Mid-stream reset while a mismatch is showing
        step("pre_rst", 8'h5a, model_crc(8'h5a) ^ 8'h80);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 8'ha5, model_crc(8'ha5));
        step("post_rst2", 8'ha5, 8'h00 ^ (model_crc(8'ha5) + 8'h01));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
